// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types used across pipeline stages.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/custom_types_pkg.sv
// Types private to the multi-cycle execute stage.
package custom_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ex_mul_state_t;

    localparam int EX_FWD_DECODE = 0;

endpackage

// File: rtl/execute_multicycle_stage_mul_iter.sv
// Radix-2 shift-add multiplier with start/flush/done handshake.
module mul_iter
    import custom_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic              flush,
    input  logic              load,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    ex_mul_state_t     state, state_n;
    logic [WORD_W-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0]  cnt;
    logic              go;

    assign go = (state == IDLE) & start & ~flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (go) state_n = RUN;
            RUN: begin
                if (flush)                   state_n = IDLE;
                else if (cnt == CNT_W'(1))   state_n = DONE;
            end
            DONE:    if (flush | load) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (go) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(WORD_W);
        end else if (flush) begin
            acc    <= '0;
        end else if (state == RUN) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    assign busy   = go | (state == RUN);
    assign done   = (state == DONE);
    assign result = acc;

endmodule

// File: rtl/execute_multicycle_stage.sv
// Execute stage: forwarding, ALU, optional iterative multiplier, EX/MEM latch.
// Define EX_MUL_EN to build in the multiplier and its stall logic.
module execute_multicycle_stage
    import cpu_types_pkg::*;
    import custom_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int NFWD   = 2,
    parameter int CTRL_W = 64,
    parameter int SEL_W  = $clog2(NFWD + 1)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   flush,
    input  logic                   freeze,
    input  aluop_t                 dec_aluop,
    input  logic                   dec_mul,
    input  logic                   dec_alusrc,
    input  logic                   dec_dREN,
    input  logic                   dec_dWEN,
    input  logic [WORD_W-1:0]      dec_port_a,
    input  logic [WORD_W-1:0]      dec_port_b,
    input  logic [WORD_W-1:0]      dec_imm,
    input  logic [CTRL_W-1:0]      dec_ctrl,
    input  logic [NFWD*WORD_W-1:0] fwd_data,
    input  logic [SEL_W-1:0]       fwd_sel_a,
    input  logic [SEL_W-1:0]       fwd_sel_b,
    output logic                   ex_busy,
    output logic [WORD_W-1:0]      ex_port_o,
    output logic [WORD_W-1:0]      ex_port_b,
    output logic                   ex_zero,
    output logic                   ex_dREN,
    output logic                   ex_dWEN,
    output logic [CTRL_W-1:0]      ex_ctrl
);

    localparam int SH_W = $clog2(WORD_W);

    logic [WORD_W-1:0] fwd_a, fwd_b, opa, opb;
    logic [WORD_W-1:0] alu_res, res;
    logic              ld;

    // Out-of-range selects fall through to the decode value.
    function automatic logic [WORD_W-1:0] fwd_pick(
        input logic [SEL_W-1:0]       sel,
        input logic [WORD_W-1:0]      dec,
        input logic [NFWD*WORD_W-1:0] data
    );
        logic [WORD_W-1:0] v;
        v = dec;
        for (int k = EX_FWD_DECODE + 1; k <= NFWD; k++)
            if (sel == SEL_W'(k)) v = data[(k-1)*WORD_W +: WORD_W];
        return v;
    endfunction

    assign fwd_a = fwd_pick(fwd_sel_a, dec_port_a, fwd_data);
    assign fwd_b = fwd_pick(fwd_sel_b, dec_port_b, fwd_data);
    assign opa   = fwd_a;
    assign opb   = dec_alusrc ? dec_imm : fwd_b;
    assign ld    = ihit & ~freeze;

    always_comb begin
        alu_res = '0;
        unique case (dec_aluop)
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_AND:  alu_res = opa & opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_NOR:  alu_res = ~(opa | opb);
            ALU_SLL:  alu_res = opb << opa[SH_W-1:0];
            ALU_SRL:  alu_res = opb >> opa[SH_W-1:0];
            ALU_SLT:  alu_res = {{(WORD_W-1){1'b0}}, $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_res = {{(WORD_W-1){1'b0}}, opa < opb};
            default:  alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic              mul_busy, mul_done;
    logic [WORD_W-1:0] mul_acc;

    mul_iter #(.WORD_W(WORD_W)) u_mul (
        .CLK    (CLK),
        .nRST   (nRST),
        .start  (dec_mul),
        .flush  (flush),
        .load   (ld),
        .a      (opa),
        .b      (opb),
        .busy   (mul_busy),
        .done   (mul_done),
        .result (mul_acc)
    );

    assign ex_busy = mul_busy;
    assign res     = dec_mul ? (mul_done ? mul_acc : '0) : alu_res;
`else
    assign ex_busy = 1'b0;
    assign res     = dec_mul ? '0 : alu_res;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_port_o <= '0;
            ex_port_b <= '0;
            ex_zero   <= 1'b0;
            ex_dREN   <= 1'b0;
            ex_dWEN   <= 1'b0;
            ex_ctrl   <= '0;
        end else if (flush & ihit) begin
            ex_port_o <= '0;
            ex_port_b <= '0;
            ex_zero   <= 1'b0;
            ex_dREN   <= 1'b0;
            ex_dWEN   <= 1'b0;
            ex_ctrl   <= '0;
        end else if (!(freeze | ex_busy)) begin
            if (ihit) begin
                ex_port_o <= res;
                ex_port_b <= fwd_b;
                ex_zero   <= (res == '0);
                ex_dREN   <= dec_dREN;
                ex_dWEN   <= dec_dWEN;
                ex_ctrl   <= dec_ctrl;
            end else if (dhit) begin
                ex_dREN   <= 1'b0;
                ex_dWEN   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_multicycle_stage.sv
// Directed bench for execute_multicycle_stage: ALU vector table plus
// hand-written latch-control and multiplier sequences.
module tb_execute_multicycle_stage;
    import cpu_types_pkg::*;
    import custom_types_pkg::*;

    localparam int W  = 32;
    localparam int NF = 2;
    localparam int CW = 64;
    localparam int SW = $clog2(NF + 1);

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit, dhit, flush, freeze;
    aluop_t        dec_aluop;
    logic          dec_mul, dec_alusrc, dec_dREN, dec_dWEN;
    logic [W-1:0]  dec_port_a, dec_port_b, dec_imm;
    logic [CW-1:0] dec_ctrl;
    logic [NF*W-1:0] fwd_data;
    logic [SW-1:0] fwd_sel_a, fwd_sel_b;
    logic          ex_busy, ex_zero, ex_dREN, ex_dWEN;
    logic [W-1:0]  ex_port_o, ex_port_b;
    logic [CW-1:0] ex_ctrl;

    execute_multicycle_stage #(.WORD_W(W), .NFWD(NF), .CTRL_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
        .freeze(freeze), .dec_aluop(dec_aluop), .dec_mul(dec_mul),
        .dec_alusrc(dec_alusrc), .dec_dREN(dec_dREN), .dec_dWEN(dec_dWEN),
        .dec_port_a(dec_port_a), .dec_port_b(dec_port_b), .dec_imm(dec_imm),
        .dec_ctrl(dec_ctrl), .fwd_data(fwd_data), .fwd_sel_a(fwd_sel_a),
        .fwd_sel_b(fwd_sel_b), .ex_busy(ex_busy), .ex_port_o(ex_port_o),
        .ex_port_b(ex_port_b), .ex_zero(ex_zero), .ex_dREN(ex_dREN),
        .ex_dWEN(ex_dWEN), .ex_ctrl(ex_ctrl)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        aluop_t       op;
        logic         src;
        logic [W-1:0] a, b, imm;
        logic [SW-1:0] sa, sb;
        logic [W-1:0] f0, f1;
        logic [W-1:0] o, pb;
        logic         z;
    } vec_t;

    vec_t v[19];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(aluop_t op, logic src, logic [W-1:0] a,
        logic [W-1:0] b, logic [W-1:0] imm, logic [SW-1:0] sa,
        logic [SW-1:0] sb, logic [W-1:0] f0, logic [W-1:0] f1,
        logic [W-1:0] o, logic [W-1:0] pb, logic z);
        vec_t r;
        r.op = op; r.src = src; r.a = a; r.b = b; r.imm = imm;
        r.sa = sa; r.sb = sb; r.f0 = f0; r.f1 = f1;
        r.o = o; r.pb = pb; r.z = z;
        return r;
    endfunction

    task automatic load_add(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [CW-1:0] ctrl);
        dec_mul = 0; dec_aluop = ALU_ADD; dec_alusrc = 0;
        fwd_sel_a = 0; fwd_sel_b = 0;
        dec_port_a = a; dec_port_b = b; dec_ctrl = ctrl;
        ihit = 1; dhit = 0; flush = 0; freeze = 0;
        step();
        ihit = 0;
    endtask

    initial begin
        nRST = 0; ihit = 0; dhit = 0; flush = 0; freeze = 0;
        dec_aluop = ALU_ADD; dec_mul = 0; dec_alusrc = 0;
        dec_dREN = 0; dec_dWEN = 0;
        dec_port_a = '0; dec_port_b = '0; dec_imm = '0; dec_ctrl = '0;
        fwd_data = '0; fwd_sel_a = '0; fwd_sel_b = '0;

        v[0]  = mk(ALU_ADD,  0, 5, 99, 0, 0, 2, 0, 7, 12, 7, 0);
        v[1]  = mk(ALU_ADD,  1, 5, 99, 1, 0, 2, 0, 7, 6, 7, 0);
        v[2]  = mk(ALU_SUB,  0, 5, 5, 0, 0, 0, 0, 0, 0, 5, 1);
        v[3]  = mk(ALU_SUB,  0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0);
        v[4]  = mk(ALU_AND,  0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 0, 0,
                   32'hF000F000, 32'hFF00FF00, 0);
        v[5]  = mk(ALU_OR,   0, 32'h0F0F0000, 32'h000000F0, 0, 0, 0, 0, 0,
                   32'h0F0F00F0, 32'h000000F0, 0);
        v[6]  = mk(ALU_XOR,  0, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 0, 0, 0,
                   32'hF0F00F0F, 32'h0F0F0F0F, 0);
        v[7]  = mk(ALU_NOR,  0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0);
        v[8]  = mk(ALU_NOR,  0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v[9]  = mk(ALU_SLL,  0, 4, 1, 0, 0, 0, 0, 0, 32'h10, 1, 0);
        v[10] = mk(ALU_SLL,  0, 33, 32'h80000001, 0, 0, 0, 0, 0, 2,
                   32'h80000001, 0);
        v[11] = mk(ALU_SRL,  0, 31, 32'h80000000, 0, 0, 0, 0, 0, 1,
                   32'h80000000, 0);
        v[12] = mk(ALU_SLT,  0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        v[13] = mk(ALU_SLTU, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        v[14] = mk(ALU_ADD,  0, 10, 1, 0, 3, 0, 100, 200, 11, 1, 0);
        v[15] = mk(ALU_ADD,  0, 10, 1, 0, 1, 0, 100, 200, 101, 1, 0);
        v[16] = mk(ALU_ADD,  0, 32'hFFFFFFFF, 2, 0, 0, 0, 0, 0, 1, 2, 0);
        v[17] = mk(ALU_ADD,  1, 1, 5, 32'hFFFFFFFF, 0, 1, 3, 0, 0, 3, 1);
        v[18] = mk(ALU_SLT,  0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0,
                   32'hFFFFFFFF, 1);

        #1;
        check("reset port_o", ex_port_o, 0);
        check("reset port_b", ex_port_b, 0);
        check("reset zero",   ex_zero, 0);
        check("reset dREN",   ex_dREN, 0);
        check("reset dWEN",   ex_dWEN, 0);
        check("reset ctrl",   ex_ctrl, 0);
        check("reset busy",   ex_busy, 0);
        step();
        nRST = 1;
        #1;

        for (int i = 0; i < 19; i++) begin
            dec_aluop = v[i].op; dec_alusrc = v[i].src;
            dec_port_a = v[i].a; dec_port_b = v[i].b; dec_imm = v[i].imm;
            fwd_sel_a = v[i].sa; fwd_sel_b = v[i].sb;
            fwd_data = {v[i].f1, v[i].f0};
            dec_dREN = i[0]; dec_dWEN = i[1];
            dec_ctrl = {32'hC0DE0000, i};
            ihit = 1;
            #1;
            check($sformatf("vec%0d busy", i), ex_busy, 0);
            step();
            check($sformatf("vec%0d port_o", i), ex_port_o, v[i].o);
            check($sformatf("vec%0d port_b", i), ex_port_b, v[i].pb);
            check($sformatf("vec%0d zero", i), ex_zero, v[i].z);
            check($sformatf("vec%0d dREN", i), ex_dREN, i[0]);
            check($sformatf("vec%0d dWEN", i), ex_dWEN, i[1]);
            check($sformatf("vec%0d ctrl", i), ex_ctrl, {32'hC0DE0000, i});
        end
        ihit = 0; fwd_data = '0;

        // dhit clears only the memory request bits
        dec_dREN = 1; dec_dWEN = 1;
        load_add(1, 2, 64'hABCD);
        check("ld dREN", ex_dREN, 1);
        dec_port_a = 50; dhit = 1;
        step();
        dhit = 0;
        check("dhit port_o", ex_port_o, 3);
        check("dhit port_b", ex_port_b, 2);
        check("dhit dREN", ex_dREN, 0);
        check("dhit dWEN", ex_dWEN, 0);
        check("dhit ctrl", ex_ctrl, 64'hABCD);

        ihit = 1; freeze = 1;
        step();
        ihit = 0; freeze = 0;
        check("freeze hold", ex_port_o, 3);

        flush = 1;
        step();
        check("flush no ihit hold", ex_port_o, 3);
        ihit = 1;
        step();
        ihit = 0; flush = 0;
        check("flush ihit port_o", ex_port_o, 0);
        check("flush ihit port_b", ex_port_b, 0);
        check("flush ihit ctrl", ex_ctrl, 0);
        dec_dREN = 0; dec_dWEN = 0;

`ifdef EX_MUL_EN
        begin
            int busy_cnt;
            load_add(1, 1, 64'h1);
            dec_mul = 1; dec_port_a = 32'hFFFFFFFF; dec_port_b = 3;
            dec_ctrl = 64'h77;
            #1;
            busy_cnt = 0;
            for (int c = 0; c < 100; c++) begin
                if (!ex_busy) break;
                busy_cnt++;
                if (c == 1) dec_port_a = 0;
                if (c == 5) ihit = 1;
                step();
            end
            check("mul busy cycles", busy_cnt, 33);
            check("mul ihit ignored", ex_port_o, 2);
            ihit = 1;
            step();
            ihit = 0; dec_mul = 0;
            #1;
            check("mul result", ex_port_o, 32'hFFFFFFFD);
            check("mul zero", ex_zero, 0);
            check("mul ctrl", ex_ctrl, 64'h77);
            check("mul busy after", ex_busy, 0);

            dec_mul = 1; dec_port_a = 3; dec_port_b = 5;
            for (int c = 0; c < 6; c++) step();
            check("mid busy", ex_busy, 1);
            nRST = 0;
            #1;
            check("rst mid port_o", ex_port_o, 0);
            check("rst mid ctrl", ex_ctrl, 0);
            check("rst mid state", dut.u_mul.state, IDLE);
            dec_mul = 0;
            step();
            nRST = 1;
            #1;
            check("rst mid busy", ex_busy, 0);

            load_add(4, 4, 64'h8);
            dec_mul = 1; dec_port_a = 9; dec_port_b = 9;
            for (int c = 0; c < 11; c++) step();
            check("run10 busy", ex_busy, 1);
            flush = 1;
            step();
            flush = 0; dec_mul = 0;
            #1;
            check("abort busy", ex_busy, 0);
            check("abort state", dut.u_mul.state, IDLE);
            check("abort hold", ex_port_o, 8);
            flush = 1; ihit = 1;
            step();
            flush = 0; ihit = 0;
            check("abort flush ihit", ex_port_o, 0);
        end
`else
        load_add(6, 6, 64'h5);
        dec_mul = 1; dec_port_a = 7; dec_port_b = 3; ihit = 1;
        #1;
        check("nomul busy", ex_busy, 0);
        step();
        ihit = 0; dec_mul = 0;
        check("nomul port_o", ex_port_o, 0);
        check("nomul zero", ex_zero, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
